// File: rtl/riscv_muldiv_pipe_pkg.sv
// Shared muldiv message definitions: op codes and field widths used by the
// muldiv unit and the core control unit that issues requests to it.
package riscv_muldiv_pipe_pkg;

    localparam int FN_W = 3;

    typedef enum logic [FN_W-1:0] {
        FN_MUL    = 3'd0,
        FN_DIV    = 3'd1,
        FN_DIVU   = 3'd2,
        FN_REM    = 3'd3,
        FN_REMU   = 3'd4,
        FN_MULH   = 3'd5,
        FN_MULHU  = 3'd6,
        FN_MULHSU = 3'd7
    } muldiv_fn_e;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_FIX,
        DIV_DONE
    } div_state_e;

    function automatic logic is_div_op(input logic [FN_W-1:0] fn);
        return (fn == FN_DIV) || (fn == FN_DIVU) || (fn == FN_REM) || (fn == FN_REMU);
    endfunction

endpackage

// File: rtl/riscv_muldiv_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// then a single sign-fix cycle; the result is held in DONE until consumed.
module riscv_muldiv_div_iter
    import riscv_muldiv_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [FN_W-1:0]  req_fn,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [WIDTH-1:0] resp_result
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_e state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quo, rem, dvs, a_keep, result;
    logic             is_rem, b_zero, neg_q, neg_r;

    logic             req_sgn;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub, q_fix, r_fix;
    logic             ge;

    // NOTE: the only register with a reset is the FSM state; the datapath
    // registers below are always loaded before they are observed.
    always_ff @(posedge clk) begin
        if (reset) state <= DIV_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (req_val)    state_nxt = DIV_CALC;
            DIV_CALC: if (cnt == '0)  state_nxt = DIV_FIX;
            DIV_FIX:                  state_nxt = DIV_DONE;
            DIV_DONE: if (resp_rdy)   state_nxt = DIV_IDLE;
            default:                  state_nxt = DIV_IDLE;
        endcase
    end

    always_comb begin
        req_rdy  = (state == DIV_IDLE);
        resp_val = (state == DIV_DONE);
    end

    always_comb begin
        req_sgn = (req_fn == FN_DIV) || (req_fn == FN_REM);
        rem_sh  = {rem, quo[WIDTH-1]};
        ge      = (rem_sh >= {1'b0, dvs});
        rem_sub = rem_sh[WIDTH-1:0] - dvs;
        q_fix   = neg_q ? -quo : quo;
        r_fix   = neg_r ? -rem : rem;
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk) begin
        case (state)
            DIV_IDLE: if (req_val) begin
                is_rem <= (req_fn == FN_REM) || (req_fn == FN_REMU);
                a_keep <= req_a;
                b_zero <= (req_b == '0);
                quo    <= (req_sgn && req_a[WIDTH-1]) ? -req_a : req_a;
                dvs    <= (req_sgn && req_b[WIDTH-1]) ? -req_b : req_b;
                rem    <= '0;
                cnt    <= CNT_W'(WIDTH - 1);
                neg_q  <= req_sgn && (req_a[WIDTH-1] ^ req_b[WIDTH-1]);
                neg_r  <= req_sgn && req_a[WIDTH-1];
            end
            DIV_CALC: begin
                rem <= ge ? rem_sub : rem_sh[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], ge};
                cnt <= cnt - CNT_W'(1);
            end
            DIV_FIX: begin
                // Divide by zero bypasses sign fixing: all-ones quotient, dividend remainder.
                if (b_zero) result <= is_rem ? a_keep : '1;
                else        result <= is_rem ? r_fix : q_fix;
            end
            default: ;
        endcase
    end

    assign resp_result = result;

endmodule

// File: rtl/riscv_muldiv_pipe.sv
// RISC-V M-extension unit: valid-tagged multiply pipeline plus an iterative
// divider, sharing one in-order val/rdy response port.
module riscv_muldiv_pipe
    import riscv_muldiv_pipe_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [FN_W-1:0]  muldivreq_msg_fn,
    input  logic [WIDTH-1:0] muldivreq_msg_a,
    input  logic [WIDTH-1:0] muldivreq_msg_b,
    input  logic             muldivreq_val,
    output logic             muldivreq_rdy,
    output logic [WIDTH-1:0] muldivresp_msg_result,
    output logic             muldivresp_val,
    input  logic             muldivresp_rdy
);

    localparam int LAST = MUL_STAGES - 1;

    logic [MUL_STAGES-1:0] stg_val;
    logic [WIDTH-1:0]      stg_res [MUL_STAGES];

    logic                  stall, mul_any_val, req_fire, is_div, mul_fire;
    logic                  div_req_val, div_req_rdy, div_resp_val, div_resp_rdy;
    logic [WIDTH-1:0]      div_result, mul_res;
    logic                  a_sgn, b_sgn;
    logic [2*WIDTH-1:0]    a_ext, b_ext, prod;

    always_comb begin
        mul_any_val    = |stg_val;
        // A finished divide waits behind any older multiply still in flight.
        muldivresp_val = !reset && (stg_val[LAST] || (div_resp_val && !mul_any_val));
        muldivresp_msg_result = stg_val[LAST] ? stg_res[LAST] : div_result;
        stall          = muldivresp_val && !muldivresp_rdy;
        muldivreq_rdy  = !reset && div_req_rdy && !stall;
        req_fire       = muldivreq_val && muldivreq_rdy;
        is_div         = is_div_op(muldivreq_msg_fn);
        mul_fire       = req_fire && !is_div;
        div_req_val    = req_fire && is_div;
        div_resp_rdy   = muldivresp_rdy && !mul_any_val;
    end

    // Sign-extend per op so one 2W-bit product serves every multiply flavour.
    always_comb begin
        a_sgn   = (muldivreq_msg_fn == FN_MULH) || (muldivreq_msg_fn == FN_MULHSU);
        b_sgn   = (muldivreq_msg_fn == FN_MULH);
        a_ext   = {{WIDTH{a_sgn & muldivreq_msg_a[WIDTH-1]}}, muldivreq_msg_a};
        b_ext   = {{WIDTH{b_sgn & muldivreq_msg_b[WIDTH-1]}}, muldivreq_msg_b};
        prod    = a_ext * b_ext;
        mul_res = (muldivreq_msg_fn == FN_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stg_val <= '0;
        end else if (!stall) begin
            stg_val[0] <= mul_fire;
            for (int i = 1; i < MUL_STAGES; i++) stg_val[i] <= stg_val[i-1];
        end
    end

    // Result registers carry no reset; the stage valids qualify them.
    always_ff @(posedge clk) begin
        if (!stall) begin
            stg_res[0] <= mul_res;
            for (int i = 1; i < MUL_STAGES; i++) stg_res[i] <= stg_res[i-1];
        end
    end

    riscv_muldiv_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk         (clk),
        .reset       (reset),
        .req_val     (div_req_val),
        .req_rdy     (div_req_rdy),
        .req_fn      (muldivreq_msg_fn),
        .req_a       (muldivreq_msg_a),
        .req_b       (muldivreq_msg_b),
        .resp_val    (div_resp_val),
        .resp_rdy    (div_resp_rdy),
        .resp_result (div_result)
    );

endmodule

// File: tb/tb_riscv_muldiv_pipe.sv
// Directed bench for riscv_muldiv_pipe (WIDTH=32, MUL_STAGES=3): latency,
// corner results, stall/hold, response ordering and mid-operation reset.
module tb_riscv_muldiv_pipe;
    import riscv_muldiv_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_fn;
    logic [31:0] req_a, req_b;
    logic        req_val, req_rdy;
    logic [31:0] result;
    logic        resp_val, resp_rdy;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    logic [31:0] got_q [$];
    logic [31:0] exp_b2b [4];

    riscv_muldiv_pipe #(.WIDTH(32), .MUL_STAGES(3)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .muldivreq_msg_fn      (req_fn),
        .muldivreq_msg_a       (req_a),
        .muldivreq_msg_b       (req_b),
        .muldivreq_val         (req_val),
        .muldivreq_rdy         (req_rdy),
        .muldivresp_msg_result (result),
        .muldivresp_val        (resp_val),
        .muldivresp_rdy        (resp_rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Each cycle window: inputs driven at posedge+1, outputs sampled at posedge+2.
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [2:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int acc, got_cyc;
        bit seen;
        logic [31:0] res;
        acc = -1; got_cyc = -1; seen = 1'b0; res = 'x;
        resp_rdy = 1'b1;
        req_fn = fn; req_a = a; req_b = b; req_val = 1'b1;
        for (int i = 0; i < 50 && acc < 0; i++) begin
            #1;
            if (req_rdy) acc = cyc;
            next_cyc();
        end
        req_val = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            #1;
            if (resp_val) begin
                seen = 1'b1; res = result; got_cyc = cyc;
            end
            next_cyc();
        end
        check({tag, "_val"}, 64'(seen), 64'd1);
        check({tag, "_res"}, 64'(res), 64'(exp));
        check({tag, "_lat"}, 64'(got_cyc - acc), 64'(lat));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int viol, cnt;
        reset = 1'b1; req_val = 1'b0; req_fn = '0; req_a = '0; req_b = '0; resp_rdy = 1'b1;
        exp_b2b[0] = 32'd6; exp_b2b[1] = 32'd20; exp_b2b[2] = 32'd42; exp_b2b[3] = 32'd72;

        repeat (3) next_cyc();
        #1;
        check("rst_rdy", 64'(req_rdy), 64'd0);
        check("rst_val", 64'(resp_val), 64'd0);
        next_cyc();
        reset = 1'b0;
        #1;
        check("rel_rdy", 64'(req_rdy), 64'd1);
        next_cyc();

        run_op("mul_7x6",  FN_MUL,    32'd7,        32'd6,        32'd42,       3);
        run_op("mul_neg",  FN_MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 3);
        run_op("mulh_min", FN_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 3);
        run_op("mulh_neg", FN_MULH,   32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 3);
        run_op("mulhu_ff", FN_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 3);
        run_op("mulhu_2",  FN_MULHU,  32'h80000000, 32'd4,        32'd2,        3);
        run_op("mulhsu",   FN_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 3);

        run_op("div_m7_2",   FN_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
        run_op("rem_m7_2",   FN_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
        run_op("divu_5_0",   FN_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 34);
        run_op("rem_ovf",    FN_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        34);
        run_op("div_ovf",    FN_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34);
        run_op("remu_5_0",   FN_REMU, 32'd5,        32'd0,        32'd5,        34);
        run_op("div_m7_0",   FN_DIV,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 34);
        run_op("rem_m7_0",   FN_REM,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 34);
        run_op("div_7_m2",   FN_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34);
        run_op("rem_7_m2",   FN_REM,  32'd7,        32'hFFFFFFFE, 32'd1,        34);
        run_op("divu_100_7", FN_DIVU, 32'd100,      32'd7,        32'd14,       34);
        run_op("remu_100_7", FN_REMU, 32'd100,      32'd7,        32'd2,        34);

        // Four back-to-back MULs; the first drains while the fourth is accepted.
        got_q.delete();
        resp_rdy = 1'b1;
        for (int w = 0; w < 4; w++) begin
            req_val = 1'b1; req_fn = FN_MUL; req_a = 32'(2*w + 2); req_b = 32'(2*w + 3);
            #1;
            check($sformatf("b2b_rdy%0d", w), 64'(req_rdy), 64'd1);
            if (resp_val && resp_rdy) got_q.push_back(result);
            next_cyc();
        end
        req_val = 1'b0; resp_rdy = 1'b0;
        for (int w = 0; w < 5; w++) begin
            #1;
            check($sformatf("stall_rdy%0d", w), 64'(req_rdy), 64'd0);
            check($sformatf("stall_hold%0d", w), 64'({resp_val, result}), 64'({1'b1, 32'd20}));
            next_cyc();
        end
        resp_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (resp_val) got_q.push_back(result);
            next_cyc();
        end
        check("b2b_count", 64'(got_q.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("b2b_res%0d", i), 64'((i < got_q.size()) ? got_q[i] : 32'hDEADBEEF),
                  64'(exp_b2b[i]));

        // MUL then DIV, response port blocked until 40 cycles after the MUL.
        resp_rdy = 1'b0;
        req_val = 1'b1; req_fn = FN_MUL; req_a = 32'd3; req_b = 32'd4;
        #1;
        check("ord_mul_rdy", 64'(req_rdy), 64'd1);
        next_cyc();
        req_fn = FN_DIVU; req_a = 32'd100; req_b = 32'd7;
        #1;
        check("ord_div_rdy", 64'(req_rdy), 64'd1);
        next_cyc();
        req_val = 1'b0;
        viol = 0;
        for (int w = 2; w < 40; w++) begin
            #1;
            if (req_rdy) viol++;
            next_cyc();
        end
        check("ord_rdy_low", 64'(viol), 64'd0);
        resp_rdy = 1'b1;
        #1;
        check("ord_first", 64'({resp_val, result}), 64'({1'b1, 32'd12}));
        next_cyc();
        #1;
        check("ord_second", 64'({resp_val, result}), 64'({1'b1, 32'd14}));
        check("ord_rdy_busy", 64'(req_rdy), 64'd0);
        next_cyc();
        #1;
        check("ord_drained", 64'({resp_val, req_rdy}), 64'({1'b0, 1'b1}));
        next_cyc();

        // Reset during CALC cycle 10 of a DIV discards it.
        resp_rdy = 1'b1;
        req_val = 1'b1; req_fn = FN_DIV; req_a = 32'd1000; req_b = 32'd3;
        #1;
        check("mr_acc", 64'(req_rdy), 64'd1);
        next_cyc();
        req_val = 1'b0;
        repeat (9) next_cyc();
        reset = 1'b1;
        #1;
        check("mr_rst", 64'({req_rdy, resp_val}), 64'({1'b0, 1'b0}));
        next_cyc();
        next_cyc();
        reset = 1'b0;
        #1;
        check("mr_rel_rdy", 64'(req_rdy), 64'd1);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            next_cyc();
            #1;
            if (resp_val) cnt++;
        end
        check("mr_noresp", 64'(cnt), 64'd0);
        next_cyc();
        run_op("mr_mul", FN_MUL, 32'd3, 32'd3, 32'd9, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
